// File: rtl/restoring_divider_seq_pkg.sv
// rtl/restoring_divider_seq_pkg.sv - shared FSM encoding and sizing helper for the restoring divider
package restoring_divider_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: counts WIDTH-1 down to 0
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/restoring_divider_seq_sub.sv
// rtl/restoring_divider_seq_sub.sv - ripple_subtractor_n: WIDTH-bit ripple chain of full-subtractor cells
module ripple_subtractor_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    logic [WIDTH:0] borrow;

    assign borrow[0] = bin;

    // One full-subtractor cell per bit; borrow ripples from LSB to MSB
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign d[i]          = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[WIDTH];

endmodule

// File: rtl/restoring_divider_seq.sv
// rtl/restoring_divider_seq.sv - multi-cycle unsigned restoring divider; optional DIVIDER_ZERO_CHECK_EN
module restoring_divider_seq
    import restoring_divider_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             take;

    // Partial remainder with next dividend bit shifted in
    assign s    = {r_reg, q_reg[WIDTH-1]};
    // Subtract succeeds when the shifted-out bit overflows WIDTH or no borrow occurs
    assign take = s[WIDTH] | ~bout;

    ripple_subtractor_n #(
        .WIDTH(WIDTH)
    ) u_sub (
        .a   (s[WIDTH-1:0]),
        .b   (m_reg),
        .bin (1'b0),
        .d   (diff),
        .bout(bout)
    );

`ifdef DIVIDER_ZERO_CHECK_EN
    logic zero_flag;
`endif

    // FSM, operand/remainder registers, iteration counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
            err       <= 1'b0;
            zero_flag <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        q_reg <= dividend;
                        m_reg <= divisor;
                        r_reg <= '0;
                        cnt   <= CNT_W'(WIDTH - 1);
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef DIVIDER_ZERO_CHECK_EN
                        err       <= 1'b0;
                        zero_flag <= (divisor == '0);
                        // Zero divisor: preload the fixed result and skip the iterations
                        if (divisor == '0) begin
                            q_reg <= '0;
                            r_reg <= dividend;
                            state <= DONE;
                        end
`endif
                    end
                    // Publish the finished result; a new start in this cycle does not disturb it
                    if (state == DONE) begin
                        done      <= 1'b1;
                        quotient  <= q_reg;
                        remainder <= r_reg;
`ifdef DIVIDER_ZERO_CHECK_EN
                        err       <= zero_flag;
`endif
                    end
                end
                RUN: begin
                    q_reg <= {q_reg[WIDTH-2:0], take};
                    r_reg <= take ? diff : s[WIDTH-1:0];
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef DIVIDER_ZERO_CHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider_seq.sv
// tb/tb_restoring_divider_seq.sv - self-checking randomized bench for restoring_divider_seq
module tb_restoring_divider_seq;

    localparam int W = 4;
`ifdef DIVIDER_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         err;

    int checks;
    int failures;

    restoring_divider_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference results derived from the arithmetic definition of division
    function automatic int ref_q(input int a, input int b);
        if (b == 0) return ZCHK ? 0 : (1 << W) - 1;
        return a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        if (b == 0) return a;
        return a % b;
    endfunction

    function automatic int ref_done_t(input int b);
        return (ZCHK && b == 0) ? 2 : W + 2;
    endfunction

    // Issue one operation and collect what the DUT reports; t=1 is the first observation after the accepting edge
    task automatic run_op(input int a, input int b, output int done_t, output int busy_n,
                          output int q, output int r, output int e);
        done_t = 0; busy_n = 0; q = -1; r = -1; e = -1;
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        step();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        for (int t = 1; t <= 40; t++) begin
            if (done) begin
                done_t = t;
                q = int'(quotient);
                r = int'(remainder);
                e = int'(err);
                break;
            end
            if (busy) busy_n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step(); step();
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (quotient !== '0) begin failures++; $display("FAIL reset_q got=%0d exp=0", quotient); end
        checks++; if (remainder !== '0) begin failures++; $display("FAIL reset_r got=%0d exp=0", remainder); end
        checks++; if (err !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int dt, bn, q, r, e;
        run_op(13, 3, dt, bn, q, r, e);
        checks++; if (dt != W + 2) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", dt, W + 2); end
        checks++; if (bn != W)     begin failures++; $display("FAIL basic_busy got=%0d exp=%0d", bn, W); end
        checks++; if (q != 4 || r != 1 || e != 0)
            begin failures++; $display("FAIL basic_result got=%0d/%0d/%0d exp=4/1/0", q, r, e); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done got=%b exp=0", busy); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (quotient !== 4'd4 || remainder !== 4'd1)
            begin failures++; $display("FAIL basic_hold got=%0d/%0d exp=4/1", quotient, remainder); end
    endtask

    task automatic test_back_to_back();
        int ndone;
        dividend = 4'd15; divisor = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 2; t <= W + 1; t++) step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_early_done got=%b exp=0", done); end
        dividend = 4'd7; divisor = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b1 || quotient !== 4'd15 || remainder !== 4'd0)
            begin failures++; $display("FAIL b2b_first got=%b/%0d/%0d exp=1/15/0", done, quotient, remainder); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble got=%b exp=1", busy); end
        ndone = 0;
        for (int t = 2; t <= W + 2; t++) begin
            step();
            if (done) ndone++;
        end
        checks++; if (done !== 1'b1 || quotient !== 4'd0 || remainder !== 4'd7 || ndone != 1)
            begin failures++; $display("FAIL b2b_second got=%b/%0d/%0d dones=%0d exp=1/0/7 dones=1", done, quotient, remainder, ndone); end
        step();
    endtask

    task automatic test_zero();
        int dt, bn, q, r, e;
        run_op(9, 0, dt, bn, q, r, e);
        checks++; if (dt != ref_done_t(0)) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", dt, ref_done_t(0)); end
        checks++; if (q != ref_q(9, 0) || r != 9 || e != int'(ZCHK))
            begin failures++; $display("FAIL zero_result got=%0d/%0d/%0d exp=%0d/9/%0d", q, r, e, ref_q(9, 0), ZCHK); end
        step();
        checks++; if (err !== ZCHK) begin failures++; $display("FAIL zero_err_hold got=%b exp=%b", err, ZCHK); end
        run_op(8, 2, dt, bn, q, r, e);
        checks++; if (dt != W + 2 || q != 4 || r != 0 || e != 0)
            begin failures++; $display("FAIL zero_follow got=%0d/%0d/%0d t=%0d exp=4/0/0 t=%0d", q, r, e, dt, W + 2); end
        step();
    endtask

    task automatic test_ignore();
        int ndone;
        ndone = 0;
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        dividend = 4'd6; divisor = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 4; t <= 16; t++) begin
            if (done) begin
                ndone++;
                checks++; if (quotient !== 4'd2 || remainder !== 4'd2)
                    begin failures++; $display("FAIL ignore_result got=%0d/%0d exp=2/2", quotient, remainder); end
            end
            step();
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    endtask

    task automatic test_abort();
        int dt, bn, q, r, e, ndone;
        dividend = 4'd14; divisor = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || err !== 1'b0)
            begin failures++; $display("FAIL abort_outputs got=%b/%b/%0d/%0d/%b exp=0/0/0/0/0", busy, done, quotient, remainder, err); end
        ndone = 0;
        for (int t = 0; t < 10; t++) begin
            if (done || busy) ndone++;
            step();
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
        run_op(14, 4, dt, bn, q, r, e);
        checks++; if (dt != W + 2 || q != 3 || r != 2)
            begin failures++; $display("FAIL abort_rerun got=%0d/%0d t=%0d exp=3/2 t=%0d", q, r, dt, W + 2); end
        step();
    endtask

    task automatic test_sweep();
        int dt, bn, q, r, e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(a, b, dt, bn, q, r, e);
                checks++;
                if (dt != W + 2 || q * b + r != a || r >= b || q != a / b || e != 0) begin
                    failures++;
                    $display("FAIL sweep %0d/%0d got=%0d r%0d e%0d t=%0d exp=%0d r%0d e0 t=%0d", a, b, q, r, e, dt, a / b, a % b, W + 2);
                end
            end
        end
    endtask

    task automatic test_random();
        int a, b, dt, bn, q, r, e;
        for (int n = 0; n < 60; n++) begin
            a = int'($urandom_range(0, 15));
            b = (n % 8 == 0) ? 0 : int'($urandom_range(0, 15));
            run_op(a, b, dt, bn, q, r, e);
            checks++;
            if (dt != ref_done_t(b) || q != ref_q(a, b) || r != ref_r(a, b) || e != int'(ZCHK && b == 0)) begin
                failures++;
                $display("FAIL random %0d/%0d got=%0d r%0d e%0d t=%0d exp=%0d r%0d e%0d t=%0d",
                         a, b, q, r, e, dt, ref_q(a, b), ref_r(a, b), ZCHK && b == 0, ref_done_t(b));
            end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero();
        test_ignore();
        test_abort();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
